wr_ptr_full_ctrl: RTL and testbench
===================================

// Module: wr_ptr_full_ctrl
// PURPOSE
//  Write-domain pointer and flag controller for the async FIFO.
//  Consumes the Gray-coded read pointer already synchronised into wr_clk by rd_2_wr_sync.
//  Owns the write pointer and drives the RAM write port.
//  Produces wr_full, wr_almost_full and the write-side fill level.
//  The Gray write pointer it outputs feeds the write-to-read synchroniser.
// PARAMETERS
//  Addr_Width  8  RAM address bits; DEPTH = 2**Addr_Width entries; pointers are Addr_Width+1 bits
//  AF_MARGIN   2  wr_almost_full asserts when level >= DEPTH-AF_MARGIN (legal 1..DEPTH-1)
// PORTS
//  wr_clk       in   1             write-domain clock
//  wr_rstn      in   1             async active-low reset
//  wr_en        in   1             write request from producer
//  rd_ptr_sync  in   Addr_Width+1  Gray read pointer, already 2-flop synchronised to wr_clk
//  wr_ovf_clr   in   1             clear sticky overflow (used only with WR_OVERFLOW_FLAG_EN)
//  wr_mem_en    out  1             RAM write strobe = wr_en & ~wr_full (combinational)
//  wr_addr      out  Addr_Width    RAM write address = wr_bin[Addr_Width-1:0]
//  wr_ptr       out  Addr_Width+1  registered Gray write pointer, to wr_2_rd_sync
//  wr_full      out  1             registered full flag
//  wr_almost_full out 1            registered almost-full flag
//  wr_level     out  Addr_Width+1  registered fill level 0..DEPTH (pessimistic)
//  wr_overflow  out  1             sticky flag: write attempted while full
// BEHAVIOUR
//  - Reset (async, wr_rstn=0): wr_bin, wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow = 0.
//    Outputs clear immediately, without waiting for a clock edge.
//  - Write is accepted when wr_en & ~wr_full at a wr_clk rising edge.
//  - On an accepted write:
//    wr_bin_nxt = wr_bin + 1 (mod 2**(Addr_Width+1)).
//    wr_gray_nxt = (wr_bin_nxt >> 1) ^ wr_bin_nxt.
//  - Write not accepted: wr_bin and wr_ptr hold.
//  - wr_ptr is registered from wr_gray_nxt, giving exactly one Gray bit change per write.
//  - rd_bin = Gray-to-binary of rd_ptr_sync (prefix XOR from MSB, combinational).
//  - Full flag:
//    wr_full <= (wr_gray_nxt == {~rd_ptr_sync[A:A-1], rd_ptr_sync[A-2:0]}), where A = Addr_Width.
//    wr_full therefore rises on the edge that accepts the DEPTH-th outstanding write.
//  - Level:
//    wr_level <= wr_bin_nxt - rd_bin (Addr_Width+1 bit modular subtract).
//    The value is correct across pointer wrap.
//  - wr_almost_full <= (wr_bin_nxt - rd_bin) >= DEPTH-AF_MARGIN.
//  - Read-pointer updates lower wr_full, wr_level and wr_almost_full one wr_clk edge after rd_ptr_sync changes.
//    Sync latency makes these flags conservative; they never report fewer entries than actually present.
//  - Simultaneous wr_en and rd_ptr_sync advance while full:
//    the write is rejected that cycle (wr_full still 1); wr_full drops on the same edge.
//  - wr_en while full: no pointer change, wr_mem_en = 0, and no RAM corruption.
//  - Reset mid-operation: pointers return to 0 and flags clear. The read side must be reset in the same episode.
// CONFIGURATION
//  WR_OVERFLOW_FLAG_EN defined:
//    - wr_overflow is set on any edge with wr_en & wr_full.
//    - wr_overflow is cleared by wr_ovf_clr; set wins if both occur on the same edge.
//  WR_OVERFLOW_FLAG_EN undefined:
//    - wr_overflow is tied to 0 and wr_ovf_clr is ignored.
//    - Ports remain present so the port list does not change.
// TESTING  (bench: Addr_Width=3, DEPTH=8, AF_MARGIN=2)
//  1. wr_rstn=0 asserted mid-burst, between edges -> all outputs 0 immediately; first write after release gives wr_addr=0.
//  2. rd_ptr_sync=0, 8 back-to-back writes:
//     wr_almost_full=1 after write 6; wr_full=1 after write 8; wr_level=8; wr_ptr=4'b1100.
//  3. Full, wr_en=1 for 3 cycles:
//     wr_mem_en=0; wr_ptr holds 4'b1100; wr_overflow=1 (macro on) or 0 (macro off).
//     With the macro on, wr_ovf_clr pulse -> wr_overflow=0.
//  4. From full, rd_ptr_sync 0000->0001:
//     next edge wr_full=0, wr_level=7, wr_almost_full=1; the following write is accepted at wr_addr=0.
//  5. 20 writes with rd_ptr_sync tracking 2 behind:
//     wr_addr wraps 7->0 twice; wr_level stays 2; wr_full never asserts.
//  6. Full, rd_ptr_sync advances on the same edge as wr_en=1:
//     that write is rejected; wr_en held -> write accepted on the next edge and wr_full re-asserts.

Source files
------------

// File: rtl/wr_ptr_full_ctrl_if.sv
// Write-side bus of the async FIFO write pointer/full controller.
// The producer and synchroniser side uses the master modport; the controller uses the slave modport.
interface wr_ptr_full_ctrl_if #(
  parameter int Addr_Width = 8
);
  logic                  wr_en;
  logic [Addr_Width:0]   rd_ptr_sync;
  logic                  wr_ovf_clr;
  logic                  wr_mem_en;
  logic [Addr_Width-1:0] wr_addr;
  logic [Addr_Width:0]   wr_ptr;
  logic                  wr_full;
  logic                  wr_almost_full;
  logic [Addr_Width:0]   wr_level;
  logic                  wr_overflow;

  modport master (
    output wr_en, rd_ptr_sync, wr_ovf_clr,
    input  wr_mem_en, wr_addr, wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow
  );

  modport slave (
    input  wr_en, rd_ptr_sync, wr_ovf_clr,
    output wr_mem_en, wr_addr, wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow
  );
endinterface

// File: rtl/wr_ptr_full_ctrl.sv
// Write-domain pointer, full/almost-full and fill-level controller of the async FIFO.
// Optional sticky overflow flag enabled by the WR_OVERFLOW_FLAG_EN macro.
module wr_ptr_full_ctrl #(
  parameter int Addr_Width = 8,
  parameter int AF_MARGIN  = 2
) (
  input  logic               wr_clk,
  input  logic               wr_rstn,
  wr_ptr_full_ctrl_if.slave  bus
);
  localparam int PW = Addr_Width + 1;
  localparam logic [PW-1:0] DEPTH_C     = {1'b1, {Addr_Width{1'b0}}};
  localparam logic [PW-1:0] AF_THRESH_C = DEPTH_C - PW'(AF_MARGIN);
  // Full means the write pointer is one lap ahead: top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK_C = {2'b11, {(Addr_Width-1){1'b0}}};

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wr_bin_r;
  logic [PW-1:0] wr_gray_r;
  logic [PW-1:0] wr_level_r;
  logic          wr_full_r;
  logic          wr_af_r;

  logic          wr_accept_s;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] wr_bin_nxt_s;
  logic [PW-1:0] wr_gray_nxt_s;
  logic [PW-1:0] level_nxt_s;

  // Next-pointer, level and flag arithmetic for the coming edge.
  always_comb begin
    wr_accept_s   = bus.wr_en & ~wr_full_r;
    rd_bin_s      = gray2bin(bus.rd_ptr_sync);
    if (wr_accept_s) begin
      wr_bin_nxt_s = wr_bin_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_bin_nxt_s = wr_bin_r;
    end
    wr_gray_nxt_s = bin2gray(wr_bin_nxt_s);
    level_nxt_s   = wr_bin_nxt_s - rd_bin_s;
  end

  // Pointer, full, almost-full and level registers.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      wr_bin_r   <= {PW{1'b0}};
      wr_gray_r  <= {PW{1'b0}};
      wr_level_r <= {PW{1'b0}};
      wr_full_r  <= 1'b0;
      wr_af_r    <= 1'b0;
    end else begin
      wr_bin_r   <= wr_bin_nxt_s;
      wr_gray_r  <= wr_gray_nxt_s;
      wr_level_r <= level_nxt_s;
      wr_full_r  <= (wr_gray_nxt_s == (bus.rd_ptr_sync ^ FULL_MASK_C));
      wr_af_r    <= (level_nxt_s >= AF_THRESH_C);
    end
  end

`ifdef WR_OVERFLOW_FLAG_EN
  logic wr_ovf_r;

  // Sticky overflow: a write attempt while full sets it and wins over a clear.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      wr_ovf_r <= 1'b0;
    end else if (bus.wr_en & wr_full_r) begin
      wr_ovf_r <= 1'b1;
    end else if (bus.wr_ovf_clr) begin
      wr_ovf_r <= 1'b0;
    end
  end

  assign bus.wr_overflow = wr_ovf_r;
`else
  logic unused_ovf_clr_s;
  assign unused_ovf_clr_s = bus.wr_ovf_clr;
  assign bus.wr_overflow  = 1'b0;
`endif

  assign bus.wr_mem_en      = wr_accept_s;
  assign bus.wr_addr        = wr_bin_r[Addr_Width-1:0];
  assign bus.wr_ptr         = wr_gray_r;
  assign bus.wr_full        = wr_full_r;
  assign bus.wr_almost_full = wr_af_r;
  assign bus.wr_level       = wr_level_r;
endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Scoreboard bench for wr_ptr_full_ctrl at Addr_Width=3, AF_MARGIN=2 (DEPTH=8).
// Expected post-edge outputs are queued by the stimulus and checked by a separate monitor.
module tb_wr_ptr_full_ctrl;
  localparam int AW = 3;
`ifdef WR_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       full;
    logic       af;
    logic [3:0] level;
    logic [3:0] ptr;
    logic       ovf;
    logic       memen;
    logic [2:0] addr;
  } exp_t;

  logic wr_clk;
  logic wr_rstn;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  wr_ptr_full_ctrl_if #(.Addr_Width(AW)) bus ();

  wr_ptr_full_ctrl #(.Addr_Width(AW), .AF_MARGIN(2)) dut (
    .wr_clk  (wr_clk),
    .wr_rstn (wr_rstn),
    .bus     (bus)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
  task automatic step(input string nm, input logic en, input logic [3:0] rd, input logic clr,
                      input logic f, input logic af, input logic [3:0] lv, input logic [3:0] pt,
                      input logic ov, input logic me, input logic [2:0] ad);
    exp_t e;
    @(negedge wr_clk);
    bus.wr_en       = en;
    bus.rd_ptr_sync = rd;
    bus.wr_ovf_clr  = clr;
    e.name = nm; e.full = f; e.af = af; e.level = lv; e.ptr = pt;
    e.ovf = ov; e.memen = me; e.addr = ad;
    exp_q.push_back(e);
    @(posedge wr_clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".full"},  8'(bus.wr_full),        8'h00);
    chk({nm, ".af"},    8'(bus.wr_almost_full), 8'h00);
    chk({nm, ".level"}, 8'(bus.wr_level),       8'h00);
    chk({nm, ".ptr"},   8'(bus.wr_ptr),         8'h00);
    chk({nm, ".ovf"},   8'(bus.wr_overflow),    8'h00);
    chk({nm, ".memen"}, 8'(bus.wr_mem_en),      8'h00);
    chk({nm, ".addr"},  8'(bus.wr_addr),        8'h00);
  endtask

  // Monitor: compare the registered outputs shortly after each rising edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge wr_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".full"},  8'(bus.wr_full),        8'(e.full));
        chk({e.name, ".af"},    8'(bus.wr_almost_full), 8'(e.af));
        chk({e.name, ".level"}, 8'(bus.wr_level),       8'(e.level));
        chk({e.name, ".ptr"},   8'(bus.wr_ptr),         8'(e.ptr));
        chk({e.name, ".ovf"},   8'(bus.wr_overflow),    8'(e.ovf));
        chk({e.name, ".memen"}, 8'(bus.wr_mem_en),      8'(e.memen));
        chk({e.name, ".addr"},  8'(bus.wr_addr),        8'(e.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] b;
    n_tests = 0;
    n_fail  = 0;
    wr_rstn = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_ptr_sync = 4'b0000;
    bus.wr_ovf_clr = 1'b0;
    #1;
    chk_all_zero("reset_init");
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    wr_rstn = 1'b1;

    // 1: burst of three writes, then async reset between edges
    for (int k = 1; k <= 3; k++) begin
      b = 4'(k);
      step("t1_burst", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, b, gray(b), 1'b0, 1'b1, b[2:0]);
    end
    #3;
    wr_rstn = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    chk_all_zero("t1_async_rst");
    @(negedge wr_clk);
    wr_rstn = 1'b1;
    #1;
    chk("t1_addr_after_rst", 8'(bus.wr_addr), 8'h00);

    // 2: eight back-to-back writes from empty
    for (int k = 1; k <= 8; k++) begin
      b = 4'(k);
      step("t2_fill", 1'b1, 4'b0000, 1'b0, (k == 8), (k >= 6), b, gray(b), 1'b0, (k < 8), b[2:0]);
    end

    // 3: writes while full are dropped; clear pulse
    for (int k = 0; k < 3; k++) begin
      step("t3_wr_full", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd8, 4'b1100, OVF_EXP, 1'b0, 3'd0);
    end
    step("t3_ovf_clr", 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'd8, 4'b1100, 1'b0, 1'b0, 3'd0);

    // 4: one read frees a slot, the next write fills it at address 0
    step("t4_rd_adv",  1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'd7, 4'b1100, 1'b0, 1'b0, 3'd0);
    step("t4_refill",  1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd8, 4'b1101, 1'b0, 1'b0, 3'd1);

    // 6: read advance on the same edge as a write while full
    step("t6_reject",  1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 4'd7, 4'b1101, OVF_EXP, 1'b1, 3'd1);
    step("t6_accept",  1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 4'd8, 4'b1111, OVF_EXP, 1'b0, 3'd2);
    step("t6_ovf_clr", 1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 4'd8, 4'b1111, 1'b0, 1'b0, 3'd2);

    // 5: reader catches up to two behind, then 20 writes with the reader tracking
    step("t5_setup",   1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'd2, 4'b1111, 1'b0, 1'b0, 3'd2);
    for (int i = 1; i <= 20; i++) begin
      b = 4'(10 + i);
      step("t5_wrap", 1'b1, gray(b - 4'd2), 1'b0, 1'b0, 1'b0, 4'd2, gray(b), 1'b0, 1'b1, b[2:0]);
    end

    @(negedge wr_clk);
    bus.wr_en = 1'b0;
    @(posedge wr_clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
